// File: rtl/regfile_write_scheduler.sv
// Single-write-port scheduler for the 32-entry register file: init sequence > interrupt PC
// capture (r26) > writeback > I/O. Define REGFILE_SCHED_RR_EN for wb/io round-robin arbitration.
module regfile_write_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GP_INIT    = 32,
    parameter int unsigned OFFSET     = 127
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  interrupt,
    input  logic [DATA_WIDTH-1:0] PC_current,
    input  logic                  wb_req,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  io_req,
    input  logic [4:0]            io_addr,
    input  logic [DATA_WIDTH-1:0] io_data,
    output logic                  wb_grant,
    output logic                  io_grant,
    output logic                  rf_we,
    output logic [4:0]            rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  irq_ack,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT_GP = 2'd1,
        ST_INIT_SP = 2'd2,
        ST_INIT_FP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_irq_pend;
    logic [DATA_WIDTH-1:0] r_irq_pc;
    logic                  r_rf_we;
    logic [4:0]            r_rf_addr;
    logic [DATA_WIDTH-1:0] r_rf_data;
    logic                  r_irq_ack;
    logic                  r_busy;

    logic                  w_we;
    logic [4:0]            w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_ack;
    logic                  w_irq_serve;
    logic                  w_wb_sel;
    logic                  w_io_sel;
    logic                  w_wb_win;

    // Handshake: wb/io hold req until grant; the write is taken in the cycle req and grant are both high.
`ifdef REGFILE_SCHED_RR_EN
    logic r_rr_io_pref;
    assign w_wb_win = wb_req && !(io_req && r_rr_io_pref);

    always_ff @(posedge clock) begin
        if (reset)         r_rr_io_pref <= 1'b0;
        else if (wb_grant) r_rr_io_pref <= 1'b1;
        else if (io_grant) r_rr_io_pref <= 1'b0;
    end
`else
    assign w_wb_win = wb_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr      = 5'd0;
        w_data      = '0;
        w_ack       = 1'b0;
        w_irq_serve = 1'b0;
        w_wb_sel    = 1'b0;
        w_io_sel    = 1'b0;
        if (start) begin
            w_state_nxt = ST_INIT_GP;
        end else begin
            case (r_state)
                ST_INIT_GP: begin
                    w_we = 1'b1; w_addr = 5'd28; w_data = DATA_WIDTH'(GP_INIT);
                    w_state_nxt = ST_INIT_SP;
                end
                ST_INIT_SP: begin
                    w_we = 1'b1; w_addr = 5'd29; w_data = DATA_WIDTH'(OFFSET);
                    w_state_nxt = ST_INIT_FP;
                end
                ST_INIT_FP: begin
                    w_we = 1'b1; w_addr = 5'd30; w_data = DATA_WIDTH'(OFFSET);
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    if (r_irq_pend) begin
                        w_irq_serve = 1'b1;
                        w_we = 1'b1; w_addr = 5'd26; w_data = r_irq_pc; w_ack = 1'b1;
                    end else if (w_wb_win) begin
                        w_wb_sel = 1'b1;
                        // r0 is hardwired: grant the request but drop the write
                        if (wb_addr != 5'd0) begin
                            w_we = 1'b1; w_addr = wb_addr; w_data = wb_data;
                        end
                    end else if (io_req) begin
                        w_io_sel = 1'b1;
                        if (io_addr != 5'd0) begin
                            w_we = 1'b1; w_addr = io_addr; w_data = io_data;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A new interrupt in the serve cycle re-arms the pending flag with the fresh PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_irq_pend <= 1'b0;
            r_irq_pc   <= '0;
        end else if (w_irq_serve) begin
            r_irq_pend <= interrupt;
            if (interrupt) r_irq_pc <= PC_current;
        end else if (interrupt && !r_irq_pend) begin
            r_irq_pend <= 1'b1;
            r_irq_pc   <= PC_current;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= 5'd0;
            r_rf_data <= '0;
            r_irq_ack <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rf_we   <= w_we;
            r_rf_addr <= w_addr;
            r_rf_data <= w_data;
            r_irq_ack <= w_ack;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign wb_grant  = w_wb_sel & ~reset;
    assign io_grant  = w_io_sel & ~reset;
    assign rf_we     = r_rf_we;
    assign rf_addr   = r_rf_addr;
    assign rf_data   = r_rf_data;
    assign irq_ack   = r_irq_ack;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: per-cycle vector table plus a hand-written restart sequence.
module tb_regfile_write_scheduler;

    localparam int DW = 32;
`ifdef REGFILE_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          interrupt = 1'b0;
    logic [DW-1:0] PC_current = '0;
    logic          wb_req = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          io_req = 1'b0;
    logic [4:0]    io_addr = '0;
    logic [DW-1:0] io_data = '0;
    logic          wb_grant, io_grant, rf_we, irq_ack, busy;
    logic [4:0]    rf_addr;
    logic [DW-1:0] rf_data;
    logic [1:0]    dbg_state;

    regfile_write_scheduler #(.DATA_WIDTH(DW), .GP_INIT(32), .OFFSET(127)) dut (
        .clock(clock), .reset(reset), .start(start), .interrupt(interrupt),
        .PC_current(PC_current), .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
        .io_req(io_req), .io_addr(io_addr), .io_data(io_data),
        .wb_grant(wb_grant), .io_grant(io_grant), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_data(rf_data), .irq_ack(irq_ack), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset block: reset is driven per vector from the table
    always #5 clock = ~clock;

    typedef struct {
        logic          rst, st, irq;
        logic [DW-1:0] pc;
        logic          wbr;
        logic [4:0]    wba;
        logic [DW-1:0] wbd;
        logic          ior;
        logic [4:0]    ioa;
        logic [DW-1:0] iod;
        logic          e_wbg, e_iog, e_we;
        logic [4:0]    e_addr;
        logic [DW-1:0] e_data;
        logic          e_ack, e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t v(input logic rst, st, irq, input logic [DW-1:0] pc,
                               input logic wbr, input logic [4:0] wba, input logic [DW-1:0] wbd,
                               input logic ior, input logic [4:0] ioa, input logic [DW-1:0] iod,
                               input logic e_wbg, e_iog, e_we, input logic [4:0] e_addr,
                               input logic [DW-1:0] e_data, input logic e_ack, e_busy);
        vec_t x;
        x.rst = rst; x.st = st; x.irq = irq; x.pc = pc;
        x.wbr = wbr; x.wba = wba; x.wbd = wbd;
        x.ior = ior; x.ioa = ioa; x.iod = iod;
        x.e_wbg = e_wbg; x.e_iog = e_iog; x.e_we = e_we;
        x.e_addr = e_addr; x.e_data = e_data; x.e_ack = e_ack; x.e_busy = e_busy;
        return x;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input vec_t x);
        reset = x.rst; start = x.st; interrupt = x.irq; PC_current = x.pc;
        wb_req = x.wbr; wb_addr = x.wba; wb_data = x.wbd;
        io_req = x.ior; io_addr = x.ioa; io_data = x.iod;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; interrupt = 1'b0; PC_current = '0;
        wb_req = 1'b0; wb_addr = '0; wb_data = '0;
        io_req = 1'b0; io_addr = '0; io_data = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t x);
        @(negedge clock);
        drive(x);
        #1;
        check($sformatf("v%0d wb_grant", idx), DW'(wb_grant), DW'(x.e_wbg));
        check($sformatf("v%0d io_grant", idx), DW'(io_grant), DW'(x.e_iog));
        @(posedge clock);
        #1;
        check($sformatf("v%0d rf_we", idx),   DW'(rf_we),   DW'(x.e_we));
        check($sformatf("v%0d rf_addr", idx), DW'(rf_addr), DW'(x.e_addr));
        check($sformatf("v%0d rf_data", idx), rf_data,      x.e_data);
        check($sformatf("v%0d irq_ack", idx), DW'(irq_ack), DW'(x.e_ack));
        check($sformatf("v%0d busy", idx),    DW'(busy),    DW'(x.e_busy));
    endtask

    initial begin
        bit found;
        //        rst st irq pc      wbr wba wbd      ior ioa iod     wbg iog we addr data   ack busy
        // reset, and reset overriding start/requests
        vecs.push_back(v(1, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 1, 1, 'h11,   1, 5, 'h55,   1, 9, 'h99,  0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        // start pulse with wb_req held: r28/r29/r30, then wb
        vecs.push_back(v(0, 1, 0, 0,      1, 5, 'h55,   0, 0, 0,     0, 0, 0, 0,  0,     0, 1));
        vecs.push_back(v(0, 0, 0, 0,      1, 5, 'h55,   0, 0, 0,     0, 0, 1, 28, 32,    0, 1));
        vecs.push_back(v(0, 0, 0, 0,      1, 5, 'h55,   0, 0, 0,     0, 0, 1, 29, 127,   0, 1));
        vecs.push_back(v(0, 0, 0, 0,      1, 5, 'h55,   0, 0, 0,     0, 0, 1, 30, 127,   0, 0));
        vecs.push_back(v(0, 0, 0, 0,      1, 5, 'h55,   0, 0, 0,     1, 0, 1, 5,  'h55,  0, 0));
        // interrupt PC=0x40 in IDLE, wb waits behind the r26 write
        vecs.push_back(v(0, 0, 1, 'h40,   0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 0, 0, 'h99,   1, 6, 'h66,   0, 0, 0,     0, 0, 1, 26, 'h40,  1, 0));
        vecs.push_back(v(0, 0, 0, 0,      1, 6, 'h66,   0, 0, 0,     1, 0, 1, 6,  'h66,  0, 0));
        // interrupts during init: second (0x80) merges into first (0x44)
        vecs.push_back(v(0, 1, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 1));
        vecs.push_back(v(0, 0, 1, 'h44,   0, 0, 0,      0, 0, 0,     0, 0, 1, 28, 32,    0, 1));
        vecs.push_back(v(0, 0, 1, 'h80,   0, 0, 0,      0, 0, 0,     0, 0, 1, 29, 127,   0, 1));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 30, 127,   0, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 26, 'h44,  1, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        // new interrupt in the serve cycle is latched and served next
        vecs.push_back(v(0, 0, 1, 'h10,   0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 0, 1, 'h20,   0, 0, 0,      0, 0, 0,     0, 0, 1, 26, 'h10,  1, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 26, 'h20,  1, 0));
        // lone io write leaves the round-robin pointer favouring wb
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      1, 3, 'h33,  0, 1, 1, 3,  'h33,  0, 0));
        // wb/io contention for four cycles
        for (int k = 0; k < 4; k++) begin
            bit io_w;
            io_w = RR && (k % 2 == 1);
            vecs.push_back(v(0, 0, 0, 0,  1, 7, 'h77,   1, 9, 'h99,  !io_w, io_w, 1,
                             io_w ? 5'd9 : 5'd7, io_w ? 32'h99 : 32'h77, 0, 0));
        end
        // writes to r0 are granted but dropped
        vecs.push_back(v(0, 0, 0, 0,      1, 0, 'hFFFF, 0, 0, 0,     1, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      1, 0, 'hAB,  0, 1, 0, 0,  0,     0, 0));
        // reset during INIT_SP aborts; a later start runs the full sequence
        vecs.push_back(v(0, 1, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 1));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 28, 32,    0, 1));
        vecs.push_back(v(1, 0, 1, 'h55,   1, 4, 'h44,   0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 1, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 1));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 28, 32,    0, 1));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 29, 127,   0, 1));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 1, 30, 127,   0, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        // reset drops an already pending interrupt
        vecs.push_back(v(0, 0, 1, 'h77,   0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(1, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));
        vecs.push_back(v(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     0, 0, 0, 0,  0,     0, 0));

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // FSM sits in IDLE after reset
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset dbg_state", DW'(dbg_state), DW'(0));

        // restart mid-sequence: start again while in INIT_SP
        @(negedge clock); idle_inputs(); start = 1'b1;
        @(posedge clock); #1;
        check("restart first busy", DW'(busy), DW'(1));
        @(negedge clock); start = 1'b0;
        @(posedge clock); #1;
        check("restart first r28 addr", DW'(rf_addr), DW'(28));
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1;
        check("restart state INIT_GP", DW'(dbg_state), DW'(1));
        check("restart busy held", DW'(busy), DW'(1));
        @(negedge clock); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(posedge clock); #1;
            if (rf_we && rf_addr == 5'd28) found = 1'b1;
        end
        check("restart r28 seen", DW'(found), DW'(1));
        @(posedge clock); #1;
        check("restart r29 addr", DW'(rf_addr), DW'(29));
        check("restart r29 data", rf_data, DW'(127));
        @(posedge clock); #1;
        check("restart r30 addr", DW'(rf_addr), DW'(30));
        check("restart r30 we", DW'(rf_we), DW'(1));
        check("restart busy low", DW'(busy), DW'(0));
        @(posedge clock); #1;
        check("restart done we", DW'(rf_we), DW'(0));

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
